// File: rtl/error_weight_pkg.sv
// Shared types and constants for the error weight allocator: FSM encoding,
// rank-to-weight mapping and the fixed pairwise comparison schedule.
package error_weight_pkg;

  typedef enum logic [1:0] {
    StAccum,
    StRank,
    StUpdate
  } state_e;

  localparam int unsigned RANK_WEIGHT_0 = 2;
  localparam int unsigned RANK_WEIGHT_1 = 1;
  localparam int unsigned RANK_WEIGHT_2 = 1;
  localparam int unsigned RANK_WEIGHT_3 = 0;
  localparam int unsigned RESET_WEIGHT  = 1;
  localparam int unsigned RANK_CYCLES   = 6;

  // Compare schedule: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
  function automatic logic [1:0] pair_lo(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: return 2'd0;
      3'd3, 3'd4:       return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pair_hi(input logic [2:0] step);
    case (step)
      3'd0:       return 2'd1;
      3'd1, 3'd3: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] rank_to_weight(input logic [1:0] rank);
    case (rank)
      2'd0:    return 2'(RANK_WEIGHT_0);
      2'd1:    return 2'(RANK_WEIGHT_1);
      2'd2:    return 2'(RANK_WEIGHT_2);
      default: return 2'(RANK_WEIGHT_3);
    endcase
  endfunction

endpackage

// File: rtl/abs_accumulator.sv
// Integrates |error| per sample; on the window-end strobe publishes the final
// sum (including the current sample) as snap_o and restarts from zero.
module abs_accumulator #(
  parameter int unsigned ERROR_WIDTH = 8,
  parameter int unsigned WINDOW_LOG2 = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 sample_valid_i,
  input  logic                                 window_end_i,
  input  logic signed [ERROR_WIDTH-1:0]        error_i,
  output logic [ERROR_WIDTH+WINDOW_LOG2-1:0]   snap_o
);

  localparam int unsigned AccWidth = ERROR_WIDTH + WINDOW_LOG2;

  logic [ERROR_WIDTH-1:0] mag;
  logic [AccWidth-1:0]    sum;
  logic [AccWidth-1:0]    acc_q, acc_d;
  logic [AccWidth-1:0]    snap_q, snap_d;

  // Unsigned negate so the most-negative input maps to 2^(ERROR_WIDTH-1).
  always_comb begin
    mag = error_i[ERROR_WIDTH-1] ? (~error_i + 1'b1) : error_i;
    sum = acc_q + AccWidth'(mag);
  end

  always_comb begin
    acc_d  = acc_q;
    snap_d = snap_q;
    if (sample_valid_i) begin
      if (window_end_i) begin
        snap_d = sum;
        acc_d  = '0;
      end else begin
        acc_d  = sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q  <= '0;
      snap_q <= '0;
    end else begin
      acc_q  <= acc_d;
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/error_weight_allocator.sv
// Ranks four error channels by windowed magnitude and publishes 2/1/1/0 weights.
// Optional ERROR_WEIGHT_FREEZE_EN adds freeze_i to hold the current weights.
module error_weight_allocator
  import error_weight_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH  = 8,
  parameter int unsigned WEIGHT_WIDTH = 3,
  parameter int unsigned WINDOW_LOG2  = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           sample_valid_i,
`ifdef ERROR_WEIGHT_FREEZE_EN
  input  logic                           freeze_i,
`endif
  input  logic signed [ERROR_WIDTH-1:0]  error_0_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_1_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_2_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_3_i,
  output logic [WEIGHT_WIDTH-1:0]        weight_0_o,
  output logic [WEIGHT_WIDTH-1:0]        weight_1_o,
  output logic [WEIGHT_WIDTH-1:0]        weight_2_o,
  output logic [WEIGHT_WIDTH-1:0]        weight_3_o,
  output logic                           weights_valid_o,
  output logic                           busy_o
);

  localparam int unsigned AccWidth = ERROR_WIDTH + WINDOW_LOG2;

  logic signed [ERROR_WIDTH-1:0] err [4];
  logic [AccWidth-1:0]           snap [4];

  logic [WINDOW_LOG2-1:0]  cnt_q;
  logic                    window_end;
  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [1:0]              rank_q [4];
  logic [1:0]              rank_d [4];
  logic [WEIGHT_WIDTH-1:0] weight_q [4];
  logic [WEIGHT_WIDTH-1:0] weight_d [4];
  logic                    valid_q, valid_d;
  logic                    busy_q;
  logic [1:0]              lo, hi;
  logic                    update_en;

  assign err[0] = error_0_i;
  assign err[1] = error_1_i;
  assign err[2] = error_2_i;
  assign err[3] = error_3_i;

  assign window_end = sample_valid_i && (cnt_q == {WINDOW_LOG2{1'b1}});

  for (genvar k = 0; k < 4; k++) begin : g_acc
    abs_accumulator #(
      .ERROR_WIDTH (ERROR_WIDTH),
      .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_acc (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .sample_valid_i (sample_valid_i),
      .window_end_i   (window_end),
      .error_i        (err[k]),
      .snap_o         (snap[k])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (sample_valid_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef ERROR_WEIGHT_FREEZE_EN
  // Freeze is sampled at window end so a release only applies to whole windows.
  logic freeze_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_q <= 1'b0;
    end else if (window_end && state_q == StAccum) begin
      freeze_q <= freeze_i;
    end
  end
  assign update_en = !freeze_q;
`else
  assign update_en = 1'b1;
`endif

  assign lo = pair_lo(step_q);
  assign hi = pair_hi(step_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rank_d   = rank_q;
    weight_d = weight_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (window_end) begin
          state_d = StRank;
          step_d  = 3'd0;
          for (int k = 0; k < 4; k++) rank_d[k] = 2'd0;
        end
      end
      StRank: begin
        // Ties go to the lower index: the higher index is ranked noisier.
        if (snap[lo] <= snap[hi]) begin
          rank_d[hi] = rank_q[hi] + 2'd1;
        end else begin
          rank_d[lo] = rank_q[lo] + 2'd1;
        end
        if (step_q == 3'(RANK_CYCLES - 1)) begin
          state_d = StUpdate;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      StUpdate: begin
        state_d = StAccum;
        if (update_en) begin
          for (int k = 0; k < 4; k++) begin
            weight_d[k] = WEIGHT_WIDTH'(rank_to_weight(rank_q[k]));
          end
          valid_d = 1'b1;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StAccum;
      step_q  <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        rank_q[k]   <= 2'd0;
        weight_q[k] <= WEIGHT_WIDTH'(RESET_WEIGHT);
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != StAccum);
      rank_q   <= rank_d;
      weight_q <= weight_d;
    end
  end

  assign weight_0_o      = weight_q[0];
  assign weight_1_o      = weight_q[1];
  assign weight_2_o      = weight_q[2];
  assign weight_3_o      = weight_q[3];
  assign weights_valid_o = valid_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_error_weight_allocator.sv
// Self-checking bench for error_weight_allocator: table of constant-error windows
// applied back to back, a scoreboard matched on weights_valid_o, and corner cases.
module tb_error_weight_allocator;

  localparam int unsigned EW   = 8;
  localparam int unsigned WW   = 3;
  localparam int unsigned WL   = 4;
  localparam int unsigned NWIN = 1 << WL;

  typedef struct {
    logic signed [EW-1:0] e0, e1, e2, e3;
    logic [15:0]          w;   // expected weights, one hex digit per channel
  } vec_t;

  typedef struct {
    logic [15:0] w;
    int          cyc;
    int          idx;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_valid = 1'b0;
  logic freeze = 1'b0;
  logic signed [EW-1:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0;
  logic [WW-1:0] w0, w1, w2, w3;
  logic weights_valid, busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  sb_t sb[$];

  error_weight_allocator #(
    .ERROR_WIDTH  (EW),
    .WEIGHT_WIDTH (WW),
    .WINDOW_LOG2  (WL)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .sample_valid_i  (sample_valid),
`ifdef ERROR_WEIGHT_FREEZE_EN
    .freeze_i        (freeze),
`endif
    .error_0_i       (e0),
    .error_1_i       (e1),
    .error_2_i       (e2),
    .error_3_i       (e3),
    .weight_0_o      (w0),
    .weight_1_o      (w1),
    .weight_2_o      (w2),
    .weight_3_o      (w3),
    .weights_valid_o (weights_valid),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] packw();
    return {1'b0, w0, 1'b0, w1, 1'b0, w2, 1'b0, w3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each call presents one sample; it is captured on the next rising edge.
  task automatic drive_sample(input logic signed [EW-1:0] a, input logic signed [EW-1:0] b,
                              input logic signed [EW-1:0] c, input logic signed [EW-1:0] d);
    sample_valid = 1'b1;
    e0 = a; e1 = b; e2 = c; e3 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input vec_t v, input bit push, input int idx);
    sb_t s;
    for (int n = 0; n < NWIN; n++) drive_sample(v.e0, v.e1, v.e2, v.e3);
    if (push) begin
      s.w = v.w; s.cyc = cyc; s.idx = idx;
      sb.push_back(s);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: %0d updates still pending after timeout, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expectation, 7 edges late.
  always @(negedge clk) begin
    if (reset_n && weights_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pulse: got weights %0h with no update expected", packw());
      end else begin
        sb_t s;
        s = sb.pop_front();
        check($sformatf("weights_win%0d", s.idx), {16'd0, packw()}, {16'd0, s.w});
        check($sformatf("latency_win%0d", s.idx), cyc - s.cyc, 7);
        check($sformatf("busy_at_pulse_win%0d", s.idx), {31'd0, busy}, 0);
      end
    end
  end

  vec_t tbl[7];

  initial begin
    vec_t v;
    tbl[0] = '{e0: 8'sd1,    e1: -8'sd3,   e2: 8'sd5,     e3: -8'sd7,   w: 16'h2110};
    tbl[1] = '{e0: -8'sd128, e1: -8'sd128, e2: -8'sd128,  e3: -8'sd128, w: 16'h2110};
    tbl[2] = '{e0: 8'sd10,   e1: 8'sd10,   e2: 8'sd10,    e3: 8'sd0,    w: 16'h1102};
    tbl[3] = '{e0: -8'sd7,   e1: 8'sd5,    e2: -8'sd3,    e3: 8'sd1,    w: 16'h0112};
    tbl[4] = '{e0: 8'sd0,    e1: 8'sd127,  e2: -8'sd128,  e3: 8'sd2,    w: 16'h2101};
    tbl[5] = '{e0: 8'sd5,    e1: -8'sd5,   e2: 8'sd5,     e3: -8'sd5,   w: 16'h2110};
    tbl[6] = '{e0: 8'sd3,    e1: -8'sd2,   e2: 8'sd1,     e3: 8'sd0,    w: 16'h0112};

    // Reset state and idle with no samples
    repeat (3) @(negedge clk);
    check("reset_weights", {16'd0, packw()}, 32'h1111);
    check("reset_valid_busy", {30'd0, weights_valid, busy}, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (15) @(negedge clk);
      check($sformatf("idle_weights_%0d", k), {16'd0, packw()}, 32'h1111);
      check($sformatf("idle_valid_busy_%0d", k), {30'd0, weights_valid, busy}, 0);
    end

    // Table windows, back to back with no gap, so samples during RANK must count
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) drive_window(tbl[i], 1'b1, i);
    // Repeat window 2 directly after window 2-style data to confirm identical result
    drive_window(tbl[2], 1'b1, 7);
    drive_window(tbl[2], 1'b1, 8);
    sample_valid = 1'b0;
    drain("table_drain");

    // Reset during RANK: partial window and next-window samples discarded
    drive_window(tbl[2], 1'b0, 0);
    check("busy_in_rank", {31'd0, busy}, 1);
    for (int n = 0; n < 3; n++) drive_sample(-8'sd128, 8'sd0, 8'sd0, 8'sd0);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("midrank_reset_weights", {16'd0, packw()}, 32'h1111);
    check("midrank_reset_valid_busy", {30'd0, weights_valid, busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_weights_hold", {16'd0, packw()}, 32'h1111);
    @(posedge clk); #1;
    drive_window(tbl[0], 1'b1, 100);
    sample_valid = 1'b0;
    drain("post_reset_drain");

`ifdef ERROR_WEIGHT_FREEZE_EN
    freeze = 1'b1;
    drive_window(tbl[2], 1'b0, 0);
    freeze = 1'b0;
    v = tbl[2];
    drive_window(v, 1'b0, 0);
    check("frozen_weights", {16'd0, packw()}, 32'h2110);
    v.e0 = 8'sd10;
    sb.push_back('{w: 16'h1102, cyc: cyc, idx: 200});
    sample_valid = 1'b0;
    drain("freeze_drain");
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
